// File: rtl/shift_74hc165.sv
// Reader for a chain of 74HC165 PISO registers.
// Pulses PL, clocks the chain MSB first, presents the word.
module shift_74hc165 #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            rd_en,
  input  logic            serial_in,
  output logic            load_n,
  output logic            register_clock,
  output logic [BITS-1:0] data_out,
  output logic            received,
  output logic            busy
);

  localparam int CW = $clog2(BITS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      shreg          <= '0;
      load_n         <= 1'b1;
      register_clock <= 1'b0;
      data_out       <= '0;
      received       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      received <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rd_en) begin
            load_n <= 1'b0;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (en) begin
            load_n <= 1'b1;
            cnt    <= '0;
            state  <= S_LO;
          end
        end
        S_LO: begin
          // Q7 settled a full tick ago; CP is low here
          if (en) begin
            shreg <= {shreg[BITS-2:0], serial_in};
            if (cnt == LAST) begin
              state <= S_DONE;
            end else begin
              register_clock <= 1'b1;
              cnt            <= cnt + CW'(1);
              state          <= S_HI;
            end
          end
        end
        S_HI: begin
          if (en) begin
            register_clock <= 1'b0;
            state          <= S_LO;
          end
        end
        S_DONE: begin
          data_out <= shreg;
          received <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_74hc165.sv
// Bench for shift_74hc165 with behavioural 74HC165 chains.
// 8-bit chain on dut8, two cascaded devices on dut16.
module tb_shift_74hc165;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        rd_en8 = 1'b0;
  logic        rd_en16 = 1'b0;
  logic        si8, si16;
  logic        ld8, cp8, rcv8, busy8;
  logic        ld16, cp16, rcv16, busy16;
  logic [7:0]  do8;
  logic [15:0] do16;

  int checks = 0;
  int failures = 0;
  bit div_mode = 1'b0;

  always #5 clk = ~clk;

  shift_74hc165 #(.BITS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en8),
    .serial_in(si8), .load_n(ld8), .register_clock(cp8),
    .data_out(do8), .received(rcv8), .busy(busy8)
  );

  shift_74hc165 #(.BITS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en16),
    .serial_in(si16), .load_n(ld16), .register_clock(cp16),
    .data_out(do16), .received(rcv16), .busy(busy16)
  );

  // hc165_model: async PL load, shift on CP rise, Q7 out
  logic [7:0] par8 = 8'h00;
  logic [7:0] dev8 = 8'h00;
  always @(negedge ld8 or posedge cp8)
    if (!ld8) dev8 <= par8;
    else      dev8 <= {dev8[6:0], 1'b0};
  assign si8 = dev8[7];

  // two cascaded devices: a drives the reader, b feeds a's DS
  logic [7:0] par_a = 8'h00, par_b = 8'h00;
  logic [7:0] dev_a = 8'h00, dev_b = 8'h00;
  always @(negedge ld16 or posedge cp16)
    if (!ld16) begin
      dev_a <= par_a;
      dev_b <= par_b;
    end else begin
      dev_a <= {dev_a[6:0], dev_b[7]};
      dev_b <= {dev_b[6:0], 1'b0};
    end
  assign si16 = dev_a[7];

  int cp8_rise = 0, pl8_fall = 0, rcv8_cnt = 0;
  int cp16_rise = 0;
  always @(posedge cp8) cp8_rise++;
  always @(negedge ld8) pl8_fall++;
  always @(posedge cp16) cp16_rise++;
  always @(posedge clk) if (rcv8) rcv8_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
    if (div_mode) en = ~en;
    else en = 1'b1;
  endtask

  // observations gathered by the read helpers
  int         lat;
  bit         tmo, busy_ok, tick_ok, hold_ok;
  logic [7:0] got8;
  logic [15:0] got16;

  task automatic read8(input logic [7:0] v, input int maxc);
    logic pl, pc, ea;
    logic [7:0] pd;
    par8 = v;
    rd_en8 = 1'b1;
    tick();
    rd_en8 = 1'b0;
    lat = 0;
    busy_ok = busy8;
    tick_ok = 1'b1;
    hold_ok = 1'b1;
    while (!rcv8 && lat < maxc) begin
      pl = ld8; pc = cp8; ea = en; pd = do8;
      tick();
      lat++;
      if (!rcv8 && !busy8) busy_ok = 1'b0;
      if ((ld8 !== pl || cp8 !== pc) && !ea) tick_ok = 1'b0;
      if (!rcv8 && do8 !== pd) hold_ok = 1'b0;
    end
    got8 = do8;
    tmo = !rcv8;
  endtask

  task automatic read16(input logic [7:0] a, input logic [7:0] b);
    par_a = a;
    par_b = b;
    rd_en16 = 1'b1;
    tick();
    rd_en16 = 1'b0;
    lat = 0;
    while (!rcv16 && lat < 200) begin
      tick();
      lat++;
    end
    got16 = do16;
    tmo = !rcv16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ld8, cp8, rcv8, busy8} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_pins8 got=%b want=1000",
               {ld8, cp8, rcv8, busy8});
    end
    checks++;
    if (do8 !== 8'h00) begin
      failures++;
      $display("FAIL reset_data8 got=%h want=00", do8);
    end
    checks++;
    if ({ld16, cp16, rcv16, busy16} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_pins16 got=%b want=1000",
               {ld16, cp16, rcv16, busy16});
    end
    checks++;
    if (do16 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data16 got=%h want=0000", do16);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_rate();
    int c0, p0;
    bit bad_rcv, bad_busy;
    bad_rcv = 0;
    bad_busy = 0;
    div_mode = 0;
    en = 1'b1;
    par8 = 8'hA5;
    c0 = cp8_rise;
    p0 = pl8_fall;
    rd_en8 = 1'b1;
    tick();
    rd_en8 = 1'b0;
    checks++;
    if (ld8 !== 1'b0 || busy8 !== 1'b1) begin
      failures++;
      $display("FAIL accept ld=%b busy=%b want 0 1", ld8, busy8);
    end
    tick();
    checks++;
    if (ld8 !== 1'b1) begin
      failures++;
      $display("FAIL pl_width ld=%b want 1", ld8);
    end
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (rcv8) bad_rcv = 1;
      if (!busy8) bad_busy = 1;
    end
    checks++;
    if (bad_rcv || bad_busy) begin
      failures++;
      $display("FAIL early rcv=%0d busylow=%0d want 0 0",
               bad_rcv, bad_busy);
    end
    tick();
    checks++;
    if (rcv8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL edge17 rcv=%b busy=%b want 1 0", rcv8, busy8);
    end
    checks++;
    if (do8 !== 8'hA5) begin
      failures++;
      $display("FAIL data_a5 got=%h want=a5", do8);
    end
    checks++;
    if (cp8_rise - c0 != 7 || pl8_fall - p0 != 1) begin
      failures++;
      $display("FAIL edges cp=%0d pl=%0d want 7 1",
               cp8_rise - c0, pl8_fall - p0);
    end
    tick();
    checks++;
    if (rcv8 !== 1'b0) begin
      failures++;
      $display("FAIL strobe_width rcv=%b want 0", rcv8);
    end
  endtask

  task automatic test_divider();
    logic [7:0] v;
    div_mode = 1;
    for (int r = 0; r < 3; r++) begin
      v = (r == 0) ? 8'h3C : 8'($urandom);
      repeat ($urandom_range(1, 2)) tick();
      read8(v, 100);
      checks++;
      if (tmo || got8 !== v) begin
        failures++;
        $display("FAIL div_data r=%0d got=%h want=%h tmo=%0d",
                 r, got8, v, tmo);
      end
      checks++;
      if (!busy_ok || !tick_ok) begin
        failures++;
        $display("FAIL div_pins r=%0d busy=%0d tick=%0d want 1 1",
                 r, busy_ok, tick_ok);
      end
      checks++;
      if (lat < 32 || lat > 35) begin
        failures++;
        $display("FAIL div_latency r=%0d got=%0d want 32..35",
                 r, lat);
      end
    end
    div_mode = 0;
    tick();
  endtask

  task automatic test_cascade();
    int c0;
    logic [7:0] a, b;
    for (int r = 0; r < 2; r++) begin
      a = (r == 0) ? 8'h12 : 8'($urandom);
      b = (r == 0) ? 8'h34 : 8'($urandom);
      c0 = cp16_rise;
      read16(a, b);
      checks++;
      if (tmo || got16 !== {a, b}) begin
        failures++;
        $display("FAIL cascade_data got=%h want=%h tmo=%0d",
                 got16, {a, b}, tmo);
      end
      checks++;
      if (cp16_rise - c0 != 15 || lat != 33) begin
        failures++;
        $display("FAIL cascade_timing cp=%0d lat=%0d want 15 33",
                 cp16_rise - c0, lat);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int r0, p0, hold, expn;
    bit bad;
    logic [7:0] v;
    v = 8'($urandom);
    par8 = v;
    r0 = rcv8_cnt;
    p0 = pl8_fall;
    bad = 0;
    hold = 40;
    // one read occupies 18 request cycles
    expn = (hold + 17) / 18;
    rd_en8 = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rcv8 && do8 !== v) bad = 1;
    end
    rd_en8 = 1'b0;
    for (int i = 0; i < 40 && busy8; i++) begin
      tick();
      if (rcv8 && do8 !== v) bad = 1;
    end
    tick();
    checks++;
    if (rcv8_cnt - r0 != expn) begin
      failures++;
      $display("FAIL b2b_received got=%0d want=%0d",
               rcv8_cnt - r0, expn);
    end
    checks++;
    if (pl8_fall - p0 != expn) begin
      failures++;
      $display("FAIL b2b_accepts got=%0d want=%0d",
               pl8_fall - p0, expn);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL b2b_data got=%h want=%h", do8, v);
    end
  endtask

  task automatic test_reset_mid();
    int c0, r0, n;
    logic [7:0] v;
    par8 = 8'($urandom);
    c0 = cp8_rise;
    rd_en8 = 1'b1;
    tick();
    rd_en8 = 1'b0;
    n = 0;
    while (cp8_rise - c0 < 3 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (cp8_rise - c0 != 3) begin
      failures++;
      $display("FAIL mid_cp_wait got=%0d want=3", cp8_rise - c0);
    end
    r0 = rcv8_cnt;
    rst = 1'b1;
    tick();
    checks++;
    if ({ld8, cp8, busy8, rcv8} !== 4'b1000 || do8 !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset pins=%b data=%h want 1000 00",
               {ld8, cp8, busy8, rcv8}, do8);
    end
    rst = 1'b0;
    repeat (20) tick();
    checks++;
    if (rcv8_cnt != r0) begin
      failures++;
      $display("FAIL mid_no_rcv got=%0d want=0", rcv8_cnt - r0);
    end
    v = 8'($urandom);
    read8(v, 40);
    checks++;
    if (tmo || got8 !== v) begin
      failures++;
      $display("FAIL mid_reread got=%h want=%h", got8, v);
    end
    tick();
  endtask

  task automatic test_hold();
    read8(8'hFF, 40);
    checks++;
    if (tmo || got8 !== 8'hFF) begin
      failures++;
      $display("FAIL hold_first got=%h want=ff", got8);
    end
    repeat (3) tick();
    checks++;
    if (do8 !== 8'hFF) begin
      failures++;
      $display("FAIL hold_idle got=%h want=ff", do8);
    end
    read8(8'h00, 40);
    checks++;
    if (!hold_ok) begin
      failures++;
      $display("FAIL hold_during data moved before received want ff");
    end
    checks++;
    if (tmo || got8 !== 8'h00) begin
      failures++;
      $display("FAIL hold_second got=%h want=00", got8);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_divider();
    test_cascade();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
